// File: rtl/message_transmitter.sv
// Serial frame generator for the 1-bit message link.
// A frame is PREAMBLE_LEN 1s, then the latched DATA_W-bit payload MSB first,
// then GUARD_LEN 0s. A start/busy/done handshake drives it.
// Optional build macro: MSG_TX_PARITY_EN inserts one even-parity bit after the
// payload.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | line low, waiting for start; done is high on the first cycle
// S_PREAMBLE | sending the run of 1s that marks the start of a frame
// S_DATA     | shifting the latched payload out, MSB first
// S_PARITY   | (MSG_TX_PARITY_EN only) sending XOR of the latched payload
// S_GUARD    | sending 0s so the far-end detector returns to idle
//
// state_q always names the phase of the bit currently on data_out. cnt_q
// counts down the bits still to come in that phase after the current one.
// When it reaches zero, the next phase begins.
`timescale 1ns/1ps

module message_transmitter #(
  parameter int PREAMBLE_LEN = 4,
  parameter int DATA_W       = 8,
  parameter int GUARD_LEN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              data_out,
  output logic              busy,
  output logic              done
);

  localparam int MAX_PD  = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GUARD_LEN) ? MAX_PD : GUARD_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  // A zero-length phase would leave the down-counter with no terminal count.
  if (PREAMBLE_LEN < 1) begin : g_bad_preamble
    $error("message_transmitter: PREAMBLE_LEN must be >= 1");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("message_transmitter: DATA_W must be >= 1");
  end
  if (GUARD_LEN < 1) begin : g_bad_guard
    $error("message_transmitter: GUARD_LEN must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_GUARD
`ifdef MSG_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              data_out_q, data_out_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
`ifdef MSG_TX_PARITY_EN
  // The shift register is consumed as the payload goes out, so the parity
  // is captured when the word is latched.
  logic              parity_q,   parity_d;
`endif

  // Next-state and next-output logic. The outputs describe the bit on the
  // line after the coming edge, so every output is a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    data_out_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef MSG_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PREAMBLE;
          cnt_d      = PRE_LOAD;
          shift_d    = data;
`ifdef MSG_TX_PARITY_EN
          parity_d   = ^data;
`endif
          data_out_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      S_PREAMBLE: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_ZERO) begin
          state_d    = S_DATA;
          cnt_d      = DATA_LOAD;
          data_out_d = shift_q[DATA_W-1];
          shift_d    = shift_q << 1;
        end else begin
          cnt_d      = cnt_q - CNT_ONE;
          data_out_d = 1'b1;
        end
      end

      S_DATA: begin
        busy_d = 1'b1;
        if (cnt_q != CNT_ZERO) begin
          cnt_d      = cnt_q - CNT_ONE;
          data_out_d = shift_q[DATA_W-1];
          shift_d    = shift_q << 1;
        end else begin
`ifdef MSG_TX_PARITY_EN
          state_d    = S_PARITY;
          data_out_d = parity_q;
`else
          state_d    = S_GUARD;
          cnt_d      = GUARD_LOAD;
          data_out_d = 1'b0;
`endif
        end
      end

`ifdef MSG_TX_PARITY_EN
      S_PARITY: begin
        busy_d     = 1'b1;
        state_d    = S_GUARD;
        cnt_d      = GUARD_LOAD;
        data_out_d = 1'b0;
      end
`endif

      S_GUARD: begin
        if (cnt_q != CNT_ZERO) begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, payload and output registers. Reset clears them at once, even mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      shift_q    <= '0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MSG_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MSG_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_message_transmitter.sv
// Self-checking bench for message_transmitter.
// The outputs are observed as a 3-bit vector {data_out, busy, done}.
// Inputs change on the falling edge. Outputs are checked on the next falling edge.
`timescale 1ns/1ps

module tb_message_transmitter;

  localparam int P = 4;
  localparam int D = 8;
  localparam int G = 1;
`ifdef MSG_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BUSY = P + D + PAR + G;
  localparam int NV = 17;

  typedef logic [2:0] obs_t;

  typedef struct {
    logic         st;
    logic [D-1:0] d;
    obs_t         exp;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [D-1:0] data;
  logic         data_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  obs_t mq[$];
  vec_t vt[NV];

  message_transmitter #(
    .PREAMBLE_LEN(P),
    .DATA_W      (D),
    .GUARD_LEN   (G)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data    (data),
    .data_out(data_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: {data_out,busy,done} got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference frame: the whole per-cycle output stream of one accepted frame,
  // ending with the done cycle.
  function automatic void push_frame(input logic [D-1:0] d);
    for (int i = 0; i < P; i++) mq.push_back(3'b110);
    for (int i = D - 1; i >= 0; i--) mq.push_back({d[i], 2'b10});
    if (PAR == 1) mq.push_back({^d, 2'b10});
    for (int i = 0; i < G; i++) mq.push_back(3'b010);
    mq.push_back(3'b001);
  endfunction

  // Expected outputs after the coming edge, given the inputs for that edge.
  // A new frame is accepted only when nothing remains of the previous one.
  function automatic obs_t model_step(input logic rst_in, input logic st, input logic [D-1:0] d);
    if (!rst_in) begin
      mq.delete();
      return 3'b000;
    end
    if (mq.size() == 0 && st) push_frame(d);
    if (mq.size() != 0) return mq.pop_front();
    return 3'b000;
  endfunction

  initial begin
    int   bcnt;
    obs_t e;
    logic r;
    logic st;
    logic [D-1:0] d;

    // ---------------- vector table: single frame of 8'hA5 ----------------
    vt[0]  = '{1'b1, 8'hA5, 3'b110};
    vt[1]  = '{1'b0, 8'h00, 3'b110};
    vt[2]  = '{1'b0, 8'h00, 3'b110};
    vt[3]  = '{1'b0, 8'h00, 3'b110};
    vt[4]  = '{1'b0, 8'h00, 3'b110};  // bit7 = 1
    vt[5]  = '{1'b0, 8'h00, 3'b010};  // bit6 = 0
    vt[6]  = '{1'b0, 8'h00, 3'b110};  // bit5 = 1
    vt[7]  = '{1'b0, 8'h00, 3'b010};  // bit4 = 0
    vt[8]  = '{1'b0, 8'h00, 3'b010};  // bit3 = 0
    vt[9]  = '{1'b0, 8'h00, 3'b110};  // bit2 = 1
    vt[10] = '{1'b0, 8'h00, 3'b010};  // bit1 = 0
    vt[11] = '{1'b0, 8'h00, 3'b110};  // bit0 = 1
`ifdef MSG_TX_PARITY_EN
    vt[12] = '{1'b0, 8'h00, 3'b010};  // parity of A5 = 0
    vt[13] = '{1'b0, 8'h00, 3'b010};  // guard
    vt[14] = '{1'b0, 8'h00, 3'b001};  // done
    vt[15] = '{1'b0, 8'h00, 3'b000};
`else
    vt[12] = '{1'b0, 8'h00, 3'b010};  // guard
    vt[13] = '{1'b0, 8'h00, 3'b001};  // done
    vt[14] = '{1'b0, 8'h00, 3'b000};
    vt[15] = '{1'b0, 8'h00, 3'b000};
`endif
    vt[16] = '{1'b0, 8'h00, 3'b000};

    // ---------------- reset held with start high ----------------
    reset = 1'b0;
    start = 1'b1;
    data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", {data_out, busy, done}, 3'b000);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", {data_out, busy, done}, 3'b000);
    end

    // ---------------- table-driven single frame ----------------
    bcnt = 0;
    for (int i = 0; i < NV; i++) begin
      start = vt[i].st;
      data  = vt[i].d;
      @(negedge clk);
      chk($sformatf("frame_a5[%0d]", i), {data_out, busy, done}, vt[i].exp);
      if (busy) bcnt++;
    end
    chk_int("frame_a5_busy_len", bcnt, FRAME_BUSY);

    // ---------------- start/data ignored while busy ----------------
    for (int j = 0; j <= FRAME_BUSY + 4; j++) begin
      start = (j == 0) || (j >= P && j < P + D);
      data  = (j == 0) ? 8'h00 : 8'hFF;
      if (j < P)               e = 3'b110;
      else if (j < FRAME_BUSY) e = 3'b010;
      else if (j == FRAME_BUSY) e = 3'b001;
      else                      e = 3'b000;
      @(negedge clk);
      chk($sformatf("busy_ignore[%0d]", j), {data_out, busy, done}, e);
    end
    start = 1'b0;

    // ---------------- back-to-back frames with start held ----------------
    mq.delete();
    for (int j = 0; j < 2 * (FRAME_BUSY + 1); j++) begin
      start = 1'b1;
      data  = 8'h0F;
      e = model_step(1'b1, 1'b1, 8'h0F);
      @(negedge clk);
      chk($sformatf("back_to_back[%0d]", j), {data_out, busy, done}, e);
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("b2b_stop_idle", {data_out, busy, done}, 3'b000);
    end

    // ---------------- asynchronous reset during the 3rd data bit ----------------
    start = 1'b1;
    data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (P + 2) @(negedge clk);
    chk("midreset_before", {data_out, busy, done}, 3'b110);
    #2 reset = 1'b0;
    #1 chk("midreset_async", {data_out, busy, done}, 3'b000);
    @(negedge clk);
    chk("midreset_hold", {data_out, busy, done}, 3'b000);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midreset_release_idle", {data_out, busy, done}, 3'b000);
    end

`ifdef MSG_TX_PARITY_EN
    // ---------------- parity bit ----------------
    for (int t = 0; t < 2; t++) begin
      logic pexp;
      d    = (t == 0) ? 8'h07 : 8'h03;
      pexp = (t == 0) ? 1'b1 : 1'b0;
      start = 1'b1;
      data  = d;
      bcnt  = 0;
      for (int k = 1; k <= FRAME_BUSY + 2; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (busy) bcnt++;
        if (k == P + D + 1) chk($sformatf("parity_bit_%h", d), {2'b00, data_out}, {2'b00, pexp});
      end
      chk_int($sformatf("parity_busy_len_%h", d), bcnt, 14);
    end
`endif

    // ---------------- randomized traffic against the reference model ----------------
    mq.delete();
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      st = ($urandom_range(0, 3) == 0);
      d  = D'($urandom);
      reset = r;
      start = st;
      data  = d;
      e = model_step(r, st, d);
      @(negedge clk);
      chk("random", {data_out, busy, done}, e);
    end
    reset = 1'b1;
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
